dk_walk_output_filter: RTL and testbench
========================================

DK_WALK_OUTPUT_FILTER -- requirements
Module: dk_walk_output_filter

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, meaning audio_clk_en pulse rate in Hz.
REQ-003 SHALL have parameter A_LP_16, default 30000, meaning low-pass coefficient as a fraction of 65536; legal range 0..65535.
REQ-004 SHALL have parameter A_HP_16, default 65, meaning DC-tracker coefficient as a fraction of 65536; legal range 0..65535; 0 disables DC removal.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port audio_clk_en, input, 1 bit: one-cycle sample strobe.
REQ-008 SHALL have port in, input, 16 bits: unsigned 555-VCO output sample, 0..65535 (0..12 V).
REQ-009 SHALL have port out, output, 16 bits: signed, DC-blocked, low-passed sample.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle pulse when out updates.
REQ-011 SHALL have port busy, output, 1 bit: high while a sample is being processed.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag for a strobe dropped while busy.

Function
REQ-013 SHALL implement FSM states IDLE, LP_MUL, HP_MUL, OUT.
- IDLE -> LP_MUL on audio_clk_en; in is captured into x on that edge (cycle 0).
- LP_MUL -> HP_MUL after exactly 8 cycles (cycles 1-8).
- HP_MUL -> OUT after exactly 8 cycles (cycles 9-16).
- OUT -> IDLE after 1 cycle (cycle 17).
REQ-014 SHALL use one shared radix-4 shift-add multiplier (2 coefficient bits per cycle) for both multiplies; no full-width parallel multiplier.
REQ-015 SHALL compute lp_next = lp + floor(((x - lp) * A_LP_16) / 65536).
- x - lp is a 17-bit signed value.
- The product is 33-bit signed; the divide is an arithmetic shift right by 16.
- lp SHALL remain within 0..65535.
REQ-016 SHALL compute dc_next = dc + floor(((lp_next - dc) * A_HP_16) / 65536), using the same width rules as REQ-015.
REQ-017 SHALL compute out = saturate(lp_next - dc_next) to the range -32768..32767.
- lp, dc, out and out_valid SHALL update together on the edge ending cycle 17.
- out_valid SHALL be high for exactly that one cycle.
REQ-018 SHALL hold busy high in LP_MUL, HP_MUL and OUT, and low in IDLE.
REQ-019 SHALL ignore audio_clk_en while busy (including during OUT), and SHALL set overrun to 1 when this happens.
- overrun SHALL clear only on reset.
REQ-020 SHALL hold out constant between out_valid pulses; in changes after capture SHALL have no effect on the sample in flight.
REQ-021 SHALL require CLOCK_RATE/SAMPLE_RATE >= 18, checked by a simulation-time assertion.

Reset
REQ-022 SHALL, while rst_n is low, force:
- FSM to IDLE;
- lp = 0, dc = 0, x = 0;
- out = 0, out_valid = 0, busy = 0, overrun = 0.
REQ-023 SHALL, on reset mid-operation, discard the sample in flight: no out_valid for it, and no partial update of lp, dc or out.
REQ-024 SHALL act on the first audio_clk_en seen at a rising edge after rst_n deasserts.

Verification
REQ-025 Idle hold: reset, in=0, strobe every 21 cycles -> out=0 throughout; out_valid 17 cycles after each strobe; busy high for cycles 1-17.
REQ-026 LP step: A_LP_16=32768, A_HP_16=0, in=27307 -> out=13653 after 1st sample, 20480 after 2nd.
REQ-027 Saturation: A_LP_16=65535, A_HP_16=0, in=65535 -> lp=65534, out=32767.
REQ-028 DC block: A_LP_16=65535, A_HP_16=32768, in=40000 -> 1st out=20000 (lp=39999, dc=19999); out decays monotonically toward 0 on later samples.
REQ-029 Overrun: strobes at cycle 0 and cycle 5 -> a single out_valid at cycle 17; overrun=1 from cycle 5 and stays set until reset.
REQ-030 Reset mid-op: rst_n low at cycle 8 of a sample with in=50000 -> no out_valid; out, lp, dc = 0; next strobe processes from lp=0.

Source files
------------

// File: rtl/dk_walk_output_filter.sv
// Output filter for the walk 555-VCO voice: one-pole low-pass followed by a DC tracker.
// Both multiplies share one radix-4 shift-add multiplier, one sample per strobe.
module dk_walk_output_filter #(
    parameter int unsigned CLOCK_RATE  = 1000000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned A_LP_16     = 30000,
    parameter int unsigned A_HP_16     = 65
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        audio_clk_en,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [15:0] A_LP = A_LP_16[15:0];
    localparam logic [15:0] A_HP = A_HP_16[15:0];

    typedef enum logic [1:0] {
        IDLE,
        LP_MUL,
        HP_MUL,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [15:0]        coef_q, coef_d;
    logic signed [33:0] acc_q, acc_d;
    logic [15:0]        x_q, x_d;
    logic [15:0]        lp_q, lp_d;
    logic [15:0]        dc_q, dc_d;
    logic [15:0]        lpn_q, lpn_d;
    logic [15:0]        dcn_q, dcn_d;
    logic [15:0]        out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic signed [16:0] mul_a;
    logic signed [18:0] pp;
    logic signed [33:0] term;
    logic signed [33:0] acc_sum;
    logic [15:0]        lp_upd;
    logic [15:0]        dc_upd;
    logic signed [16:0] sat_diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            coef_q      <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            lp_q        <= '0;
            dc_q        <= '0;
            lpn_q       <= '0;
            dcn_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coef_q      <= coef_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            lp_q        <= lp_d;
            dc_q        <= dc_d;
            lpn_q       <= lpn_d;
            dcn_q       <= dcn_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coef_d      = coef_q;
        acc_d       = acc_q;
        x_d         = x_q;
        lp_d        = lp_q;
        dc_d        = dc_q;
        lpn_d       = lpn_q;
        dcn_d       = dcn_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            LP_MUL:  mul_a = {1'b0, x_q} - {1'b0, lp_q};
            HP_MUL:  mul_a = {1'b0, lpn_q} - {1'b0, dc_q};
            default: mul_a = '0;
        endcase

        // Coefficient is consumed LSB-first, two bits per cycle.
        case (coef_q[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = {{2{mul_a[16]}}, mul_a};
            2'd2:    pp = {mul_a[16], mul_a, 1'b0};
            default: pp = {{2{mul_a[16]}}, mul_a} + {mul_a[16], mul_a, 1'b0};
        endcase

        term    = {{15{pp[18]}}, pp} << {cnt_q, 1'b0};
        acc_sum = acc_q + term;

        // Updated values always land in 0..65535, so the low 16 bits of the
        // floored step are enough to form them.
        lp_upd   = lp_q + acc_sum[31:16];
        dc_upd   = dc_q + acc_sum[31:16];
        sat_diff = {1'b0, lpn_q} - {1'b0, dcn_q};

        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    x_d     = in;
                    coef_d  = A_LP;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = LP_MUL;
                end
            end
            LP_MUL: begin
                acc_d  = acc_sum;
                coef_d = coef_q >> 2;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    lpn_d   = lp_upd;
                    acc_d   = '0;
                    coef_d  = A_HP;
                    state_d = HP_MUL;
                end
            end
            HP_MUL: begin
                acc_d  = acc_sum;
                coef_d = coef_q >> 2;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    dcn_d   = dc_upd;
                    acc_d   = '0;
                    state_d = OUT;
                end
            end
            default: begin
                lp_d        = lpn_q;
                dc_d        = dcn_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
                if (sat_diff[16] != sat_diff[15]) begin
                    out_d = sat_diff[16] ? 16'h8000 : 16'h7FFF;
                end else begin
                    out_d = sat_diff[15:0];
                end
            end
        endcase

        if (audio_clk_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

    // A full sample takes 18 clocks, so strobes must be at least that far apart.
    rate_ratio_ok: assert property (@(posedge clk) (CLOCK_RATE / SAMPLE_RATE) >= 18);

endmodule

// File: tb/tb_dk_walk_output_filter.sv
// Scoreboard bench for dk_walk_output_filter: three instances with different
// coefficients share clock, reset and strobe; expected outputs are hand-computed.
module tb_dk_walk_output_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] in0 = '0, in1 = '0, in2 = '0;
    logic [15:0] o0, o1, o2;
    logic        v0, v1, v2, b0, b1, b2, ov0, ov1, ov2;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        int unsigned at;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dk_walk_output_filter #(.A_LP_16(32768), .A_HP_16(0)) u_lp (
        .clk(clk), .rst_n(rst_n), .audio_clk_en(en), .in(in0),
        .out(o0), .out_valid(v0), .busy(b0), .overrun(ov0));

    dk_walk_output_filter #(.A_LP_16(65535), .A_HP_16(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .audio_clk_en(en), .in(in1),
        .out(o1), .out_valid(v1), .busy(b1), .overrun(ov1));

    dk_walk_output_filter #(.A_LP_16(65535), .A_HP_16(32768)) u_dc (
        .clk(clk), .rst_n(rst_n), .audio_clk_en(en), .in(in2),
        .out(o2), .out_valid(v2), .busy(b2), .overrun(ov2));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (v0 || v1 || v2) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid=%b%b%b, expected none (cycle %0d)",
                             v0, v1, v2, cyc);
                end else begin
                    e = q.pop_front();
                    chk("valid_together", {13'b0, v0, v1, v2}, 16'h0007);
                    chk("latency", cyc[15:0], e.at[15:0]);
                    chk("out_lp", o0, e.e0);
                    chk("out_sat", o1, e.e1);
                    chk("out_dc", o2, e.e2);
                end
            end
        end
    endtask

    // Drives a strobe on the next rising edge; call just after a falling edge.
    task automatic issue(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                         input logic push, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2);
        in0 = a0;
        in1 = a1;
        in2 = a2;
        en  = 1'b1;
        if (push) q.push_back('{cyc + 18, e0, e1, e2});
        @(negedge clk);
        en  = 1'b0;
        in0 = 16'($urandom());
        in1 = 16'($urandom());
        in2 = 16'($urandom());
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_lp[5];
        logic [15:0] exp_dc[5];
        exp_lp = '{16'd13653, 16'd20480, 16'd23893, 16'd25600, 16'd26453};
        exp_dc = '{16'd20000, 16'd10000, 16'd5000, 16'd2500, 16'd1250};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_out", o0, 16'd0);
        chk("reset_valid", {15'b0, v0}, 16'd0);
        chk("reset_busy", {15'b0, b0}, 16'd0);
        chk("reset_overrun", {15'b0, ov0}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero input: output stays zero, busy spans cycles 1..17.
        for (int s = 0; s < 3; s++) begin
            chk("idle_busy_pre", {15'b0, b0}, 16'd0);
            issue(16'd0, 16'd0, 16'd0, 1'b1, 16'd0, 16'd0, 16'd0);
            for (int k = 1; k <= 18; k++) begin
                chk("idle_busy", {15'b0, b0}, (k <= 17) ? 16'd1 : 16'd0);
                if (k < 18) @(negedge clk);
            end
            repeat (3) @(negedge clk);
        end
        drain();

        // Low-pass step, saturation and DC removal on repeated samples.
        for (int s = 0; s < 5; s++) begin
            issue(16'd27307, 16'd65535, 16'd40000, 1'b1, exp_lp[s], 16'd32767, exp_dc[s]);
            repeat (20) @(negedge clk);
        end
        drain();

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset2_out", o0, 16'd0);
        rst_n = 1'b1;

        // Strobe on the first edge after reset, second strobe dropped at cycle 5.
        issue(16'd27307, 16'd65535, 16'd40000, 1'b1, 16'd13653, 16'd32767, 16'd20000);
        repeat (3) @(negedge clk);
        chk("overrun_before", {15'b0, ov0}, 16'd0);
        @(negedge clk);
        en  = 1'b1;
        in0 = 16'd999;
        in1 = 16'd999;
        in2 = 16'd999;
        chk("overrun_at_strobe", {15'b0, ov0}, 16'd0);
        @(negedge clk);
        en = 1'b0;
        chk("overrun_set", {13'b0, ov0, ov1, ov2}, 16'h0007);
        drain();
        repeat (10) @(negedge clk);
        chk("overrun_sticky", {15'b0, ov0}, 16'd1);

        // Reset at cycle 8 of a sample: nothing emerges, state returns to zero.
        issue(16'd50000, 16'd50000, 16'd50000, 1'b0, 16'd0, 16'd0, 16'd0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_lp", o0, 16'd0);
        chk("midreset_out_dc", o2, 16'd0);
        chk("midreset_busy", {15'b0, b0}, 16'd0);
        chk("midreset_overrun", {15'b0, ov0}, 16'd0);
        chk("midreset_valid", {15'b0, v0}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'd27307, 16'd65535, 16'd40000, 1'b1, 16'd13653, 16'd32767, 16'd20000);
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
